// File: rtl/core_alu_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M/RV64M multiply/divide unit.
// Op indices address the internal 8-bit one-hot op vector.
package core_alu_muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OP_W     = 8;

    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHSU = 2;
    localparam int OP_MULHU  = 3;
    localparam int OP_DIV    = 4;
    localparam int OP_DIVU   = 5;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_divrem(input logic [OP_W-1:0] op);
        return op[OP_DIV] | op[OP_DIVU] | op[OP_REM] | op[OP_REMU];
    endfunction

endpackage

// File: rtl/core_alu_muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// START/KILL/op select/operands flow in; BUSY/DONE/RESULT flow back.
interface core_alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic            i_mul;
    logic            i_mulh;
    logic            i_mulhsu;
    logic            i_mulhu;
    logic            i_div;
    logic            i_divu;
    logic            i_rem;
    logic            i_remu;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, i_mul, i_mulh, i_mulhsu, i_mulhu,
               i_div, i_divu, i_rem, i_remu, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, i_mul, i_mulh, i_mulhsu, i_mulhu,
               i_div, i_divu, i_rem, i_remu, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/core_alu_muldiv_step.sv
// One combinational iteration: radix-2 shift-add (multiply) or non-restoring shift-subtract (divide).
// Divide mode leaves acc_o[0] clear; the caller merges q_bit_o into it.
module core_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_mode_i,
    input  logic [2*XLEN+1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN+1:0] acc_o,
    output logic              q_bit_o
);
    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] rem;
    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] rem_new;
    logic [XLEN+1:0] dvs_ext;

    always_comb begin
        acc_o   = '0;
        q_bit_o = 1'b0;
        mul_sum = '0;
        rem     = acc_i[2*XLEN+1:XLEN];
        rem_sh  = '0;
        rem_new = '0;
        dvs_ext = {2'b00, opnd_i};
        if (!div_mode_i) begin
            // {carry, hi} accumulates the partial sum; lo shifts out the consumed multiplier bit
            mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
            acc_o   = {2'b00, mul_sum, acc_i[XLEN-1:1]};
        end else begin
            // The partial remainder may go negative; its sign picks add or subtract next step
            rem_sh  = {rem[XLEN:0], acc_i[XLEN-1]};
            rem_new = rem[XLEN+1] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
            q_bit_o = ~rem_new[XLEN+1];
            acc_o   = {rem_new, acc_i[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/core_alu_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide: XLEN+2 cycles normal, 1 cycle for div special cases/invalid ops.
// Pipeline stalls on BUSY; START is ignored while busy; KILL aborts any non-idle state with no DONE.
module core_alu_muldiv
    import core_alu_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input logic              clk,
    input logic              rst_n,
    core_alu_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int ACC_W = 2 * XLEN + 2;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg1_q, neg1_d;
    logic              neg2_q, neg2_d;
    logic [XLEN-1:0]   fin_q, fin_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [OP_W-1:0]   req_op;
    logic              req_valid;
    logic              req_sgn1, req_sgn2;
    logic              req_neg1, req_neg2;
    logic [XLEN-1:0]   req_abs1, req_abs2;
    logic              req_div0, req_ovf;
    logic [XLEN-1:0]   req_special;

    logic [ACC_W-1:0]  step_acc;
    logic              step_q;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_lo;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   out_sel;

    assign req_op = {bus.i_remu, bus.i_rem, bus.i_divu, bus.i_div,
                     bus.i_mulhu, bus.i_mulhsu, bus.i_mulh, bus.i_mul};

    always_comb begin
        req_valid   = $onehot(req_op);
        req_sgn1    = req_op[OP_MUL] | req_op[OP_MULH] | req_op[OP_MULHSU] | req_op[OP_DIV] | req_op[OP_REM];
        req_sgn2    = req_op[OP_MUL] | req_op[OP_MULH] | req_op[OP_DIV] | req_op[OP_REM];
        req_neg1    = req_sgn1 & bus.rs1[XLEN-1];
        req_neg2    = req_sgn2 & bus.rs2[XLEN-1];
        req_abs1    = req_neg1 ? -bus.rs1 : bus.rs1;
        req_abs2    = req_neg2 ? -bus.rs2 : bus.rs2;
        req_div0    = is_divrem(req_op) & (bus.rs2 == '0);
        req_ovf     = (req_op[OP_DIV] | req_op[OP_REM]) & (bus.rs1 == MOST_NEG) & (bus.rs2 == '1);
        req_special = '0;
        if (req_div0) begin
            req_special = (req_op[OP_DIV] | req_op[OP_DIVU]) ? '1 : bus.rs1;
        end else if (req_ovf) begin
            req_special = req_op[OP_DIV] ? bus.rs1 : '0;
        end
    end

    core_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .div_mode_i (is_divrem(op_q)),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc),
        .q_bit_o    (step_q)
    );

    // Non-restoring division can end with a negative remainder; one add of the divisor corrects it
    always_comb begin
        prod_fix = (neg1_q ^ neg2_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        quo_fix  = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_lo   = acc_q[ACC_W-1] ? (acc_q[2*XLEN-1:XLEN] + opnd_q) : acc_q[2*XLEN-1:XLEN];
        rem_fix  = neg1_q ? -rem_lo : rem_lo;
        out_sel  = '0;
        if (op_q[OP_MUL]) begin
            out_sel = prod_fix[XLEN-1:0];
        end else if (op_q[OP_MULH] | op_q[OP_MULHSU] | op_q[OP_MULHU]) begin
            out_sel = prod_fix[2*XLEN-1:XLEN];
        end else if (op_q[OP_DIV] | op_q[OP_DIVU]) begin
            out_sel = quo_fix;
        end else if (op_q[OP_REM] | op_q[OP_REMU]) begin
            out_sel = rem_fix;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        fin_d   = fin_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = req_op;
                    acc_d   = {{(XLEN+2){1'b0}}, req_abs1};
                    opnd_d  = req_abs2;
                    neg1_d  = req_neg1;
                    neg2_d  = req_neg2;
                    cnt_d   = CNT_W'(XLEN);
                    busy_d  = 1'b1;
                    if (!req_valid) begin
                        fin_d   = '0;
                        state_d = ST_FIN;
                    end else if (req_div0 | req_ovf) begin
                        fin_d   = req_special;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step_acc | {{(ACC_W-1){1'b0}}, step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fin_d   = out_sel;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                res_d   = fin_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over everything, including the final result write
        if (bus.kill && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            fin_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            fin_q   <= fin_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;

endmodule

// File: tb/tb_core_alu_muldiv.sv
// Bench for core_alu_muldiv at XLEN=32: directed vector table, KILL/reset sequences, random ops vs. arithmetic model.
module tb_core_alu_muldiv;
    localparam int XLEN     = 32;
    localparam int NORM_LAT = XLEN + 2;

    localparam logic [7:0] O_MUL    = 8'h01;
    localparam logic [7:0] O_MULH   = 8'h02;
    localparam logic [7:0] O_MULHSU = 8'h04;
    localparam logic [7:0] O_MULHU  = 8'h08;
    localparam logic [7:0] O_DIV    = 8'h10;
    localparam logic [7:0] O_DIVU   = 8'h20;
    localparam logic [7:0] O_REM    = 8'h40;
    localparam logic [7:0] O_REMU   = 8'h80;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_alu_muldiv_if #(.XLEN(XLEN)) bus ();

    core_alu_muldiv #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] o);
        bus.i_mul    = o[0];
        bus.i_mulh   = o[1];
        bus.i_mulhsu = o[2];
        bus.i_mulhu  = o[3];
        bus.i_div    = o[4];
        bus.i_divu   = o[5];
        bus.i_rem    = o[6];
        bus.i_remu   = o[7];
    endtask

    // Behavioural reference: plain 64-bit arithmetic on the RISC-V M-extension rules
    function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            O_MUL:    begin p = sa * sb; return p[31:0]; end
            O_MULH:   begin p = sa * sb; return p[63:32]; end
            O_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            O_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            O_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            O_REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            O_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            O_REMU:   return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!$onehot(op)) return 1;
        if ((op & 8'hF0) != 0 && b == 0) return 1;
        if ((op == O_DIV || op == O_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a falling edge; the request is taken at the next rising edge (edge 0).
    // Ends on the falling edge where DONE is seen, so consecutive calls run back-to-back.
    task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int poke);
        int lat;
        int busy_cnt;
        bus.start = 1'b1;
        set_op(op);
        bus.rs1 = a;
        bus.rs2 = b;
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        set_op(8'h00);
        chk({name, " done-low-after-start"}, 64'(bus.done), 64'(0));
        while (!bus.done && lat < 200) begin
            if (bus.busy) busy_cnt++;
            if (lat == poke) begin
                bus.start = 1'b1;
                set_op(O_DIV);
                bus.rs1 = $urandom;
                bus.rs2 = $urandom | 32'h1;
            end else begin
                bus.start = 1'b0;
                set_op(8'h00);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        set_op(8'h00);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " busy-cycles"}, 64'(busy_cnt), 64'(exp_lat));
        chk({name, " busy-at-done"}, 64'(bus.busy), 64'(0));
        chk({name, " result"}, 64'(bus.result), 64'(exp_res));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_res;
        logic [7:0]  rop;
        logic [31:0] ra, rb;
        int          done_seen;

        rst_n    = 1'b0;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        set_op(8'h00);
        bus.rs1 = '0;
        bus.rs2 = '0;
        #3;
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset done", 64'(bus.done), 64'(0));
        chk("reset result", 64'(bus.result), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back('{"mul 7*-3",         O_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT});
        vecs.push_back('{"mulh min*min",     O_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, NORM_LAT});
        vecs.push_back('{"mulhu max*max",    O_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT});
        vecs.push_back('{"mulhsu -1*max",    O_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, NORM_LAT});
        vecs.push_back('{"div -7/2",         O_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, NORM_LAT});
        vecs.push_back('{"rem -7/2",         O_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, NORM_LAT});
        vecs.push_back('{"divu fff9/2",      O_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, NORM_LAT});
        vecs.push_back('{"remu 100/7",       O_REMU,   32'd100,        32'd7,         32'd2,         NORM_LAT});
        vecs.push_back('{"divu 5/0",         O_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"rem 5/0",          O_REM,    32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{"div ovf",          O_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{"rem ovf",          O_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{"mul|div invalid",  O_MUL | O_DIV, 32'd9,     32'd3,         32'h0,         1});
        vecs.push_back('{"no-op invalid",    8'h00,    32'd9,          32'd3,         32'h0,         1});
        vecs.push_back('{"divu big/max",     O_DIVU,   32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'h0,         NORM_LAT});
        vecs.push_back('{"remu big/max",     O_REMU,   32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, -1);
        end
        last_res = 32'hFFFF_FFFE;

        // A second START while busy must not disturb the running multiply
        run_op("mul start-while-busy", O_MUL, 32'd1234, 32'd5678, 32'd7006652, NORM_LAT, 5);
        last_res = 32'd7006652;

        // KILL during DIV: seen at the rising edge after edge 10
        bus.start = 1'b1;
        set_op(O_DIV);
        bus.rs1 = 32'd100;
        bus.rs2 = 32'd7;
        done_seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            set_op(8'h00);
            if (bus.done) done_seen++;
            if (k == 11) chk("kill busy after", 64'(bus.busy), 64'(0));
            if (k == 10) begin
                chk("kill busy before", 64'(bus.busy), 64'(1));
                bus.kill = 1'b1;
            end else begin
                bus.kill = 1'b0;
            end
        end
        chk("kill no done", 64'(done_seen), 64'(0));
        chk("kill result held", 64'(bus.result), 64'(last_res));
        run_op("div 100/7 after kill", O_DIV, 32'd100, 32'd7, 32'd14, NORM_LAT, -1);
        run_op("rem 100/7", O_REM, 32'd100, 32'd7, 32'd2, NORM_LAT, -1);
        last_res = 32'd2;

        // KILL in IDLE is ignored; KILL held into FIN suppresses the fast-path result
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        set_op(O_DIVU);
        bus.rs1 = 32'd5;
        bus.rs2 = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        set_op(8'h00);
        chk("kill-idle start accepted", 64'(bus.busy), 64'(1));
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill-fin no done", 64'(bus.done), 64'(0));
        chk("kill-fin busy", 64'(bus.busy), 64'(0));
        chk("kill-fin result held", 64'(bus.result), 64'(last_res));

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) rop = 8'($urandom);
            else rop = 8'h01 << $urandom_range(0, 7);
            ra = rnd_operand();
            rb = rnd_operand();
            run_op($sformatf("rand%0d op%0h %0h,%0h", i, rop, ra, rb), rop, ra, rb,
                   ref_res(rop, ra, rb), ref_lat(rop, ra, rb), -1);
        end

        // Asynchronous reset in the middle of CALC
        run_op("mul 3*5", O_MUL, 32'd3, 32'd5, 32'd15, NORM_LAT, -1);
        bus.start = 1'b1;
        set_op(O_MUL);
        bus.rs1 = 32'd7;
        bus.rs2 = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        set_op(8'h00);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 64'(bus.busy), 64'(0));
        chk("async rst done", 64'(bus.done), 64'(0));
        chk("async rst result", 64'(bus.result), 64'(0));
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (NORM_LAT) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("async rst no done", 64'(done_seen), 64'(0));
        run_op("mul after reset", O_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
